conv_window_gen: RTL and testbench



---
 rtl/conv_window_gen.sv | 224 ++++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// conv_window_gen: parametrised KxK sliding-window generator.
// Buffers K-1 lines and emits one flattened window per stride hit.
module conv_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 1,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int KERNEL     = 5,
    parameter int STRIDE     = 1,
    localparam int PIX_W     = DATA_WIDTH * CHANNELS,
    localparam int XW        = $clog2(IMG_WIDTH),
    localparam int YW        = $clog2(IMG_HEIGHT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [PIX_W-1:0]                in_data,
    input  logic                            in_sof,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [KERNEL*KERNEL*PIX_W-1:0]  win_out,
    output logic                            win_first,
    output logic                            win_last,
    output logic [XW-1:0]                   out_x,
    output logic [YW-1:0]                   out_y
);

    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OW = (IMG_WIDTH - KERNEL) / STRIDE + 1;
    localparam int OH = (IMG_HEIGHT - KERNEL) / STRIDE + 1;

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0] X_K     = XW'(KERNEL - 1);
    localparam logic [YW-1:0] Y_K     = YW'(KERNEL - 1);
    localparam logic [XW-1:0] OX_LAST = XW'(OW - 1);
    localparam logic [YW-1:0] OY_LAST = YW'(OH - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(STRIDE - 1);

    logic              rdy_en;
    logic              acc;

    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;
    logic [SW-1:0]     xph;
    logic [SW-1:0]     yph;
    logic [XW-1:0]     ox_cnt;
    logic [YW-1:0]     oy_cnt;

    // position and stride phase of the pixel being offered
    logic [XW-1:0]     px;
    logic [YW-1:0]     py;
    logic [SW-1:0]     cur_xph;
    logic [SW-1:0]     cur_yph;
    logic [XW-1:0]     cur_ox;
    logic [YW-1:0]     cur_oy;
    logic              x_end;
    logic              y_end;
    logic              win_hit;

    logic [SW-1:0]     xph_n;
    logic [XW-1:0]     ox_n;
    logic [SW-1:0]     yph_n;
    logic [YW-1:0]     oy_n;

    logic [PIX_W-1:0]  lb  [KERNEL-1][IMG_WIDTH];
    logic [PIX_W-1:0]  tap [KERNEL-1];
    logic [PIX_W-1:0]  col [KERNEL];

    // Older K-1 columns are registered; the newest column is the
    // live input column, so the window is complete on the accept edge.
    logic [PIX_W-1:0]  win [KERNEL][KERNEL-1];
    logic [KERNEL*KERNEL*PIX_W-1:0] win_nxt;

    assign in_ready = rdy_en && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;

    assign px       = in_sof ? '0 : x_cnt;
    assign py       = in_sof ? '0 : y_cnt;
    assign cur_xph  = in_sof ? '0 : xph;
    assign cur_yph  = in_sof ? '0 : yph;
    assign cur_ox   = in_sof ? '0 : ox_cnt;
    assign cur_oy   = in_sof ? '0 : oy_cnt;
    assign x_end    = (px == X_LAST);
    assign y_end    = (py == Y_LAST);

    assign win_hit  = (px >= X_K) && (py >= Y_K) &&
                      (cur_xph == '0) && (cur_yph == '0);

    // stride phase and output index for the column after px
    always_comb begin
        xph_n = '0;
        ox_n  = '0;
        if (!x_end && (px >= X_K)) begin
            if (cur_xph == S_LAST) begin
                xph_n = '0;
                ox_n  = cur_ox + 1'b1;
            end else begin
                xph_n = cur_xph + 1'b1;
                ox_n  = cur_ox;
            end
        end
    end

    // stride phase and output index for the line after py
    always_comb begin
        yph_n = '0;
        oy_n  = '0;
        if (!y_end && (py >= Y_K)) begin
            if (cur_yph == S_LAST) begin
                yph_n = '0;
                oy_n  = cur_oy + 1'b1;
            end else begin
                yph_n = cur_yph + 1'b1;
                oy_n  = cur_oy;
            end
        end
    end

    // line-buffer taps at the current column
    always_comb begin
        for (int j = 0; j < KERNEL - 1; j++) begin
            tap[j] = lb[j][px];
        end
    end

    // column entering the window: bottom row is the live pixel
    always_comb begin
        for (int r = 0; r < KERNEL - 1; r++) begin
            col[r] = tap[KERNEL-2-r];
        end
        col[KERNEL-1] = in_data;
    end

    // flattened window as it stands after this pixel shifts in
    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_nxt[(r*KERNEL+c)*PIX_W +: PIX_W] = win[r][c];
            end
            win_nxt[(r*KERNEL+KERNEL-1)*PIX_W +: PIX_W] = col[r];
        end
    end

    // cascaded line buffers, addressed by column
    always_ff @(posedge clk) begin
        if (acc) begin
            lb[0][px] <= in_data;
            for (int j = 1; j < KERNEL - 1; j++) begin
                lb[j][px] <= tap[j-1];
            end
        end
    end

    // window column shift, oldest column drops out at c=0
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL - 2; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][KERNEL-2] <= col[r];
            end
        end
    end

    // input enable rises one cycle after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // raster position and stride phase counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            xph    <= '0;
            yph    <= '0;
            ox_cnt <= '0;
            oy_cnt <= '0;
        end else if (acc) begin
            x_cnt  <= x_end ? '0 : px + 1'b1;
            xph    <= xph_n;
            ox_cnt <= ox_n;
            if (x_end) begin
                y_cnt  <= y_end ? '0 : py + 1'b1;
                yph    <= yph_n;
                oy_cnt <= oy_n;
            end else begin
                y_cnt  <= py;
                yph    <= cur_yph;
                oy_cnt <= cur_oy;
            end
        end
    end

    // output register: load on hit, clear on consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            win_out   <= '0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (acc && win_hit) begin
            out_valid <= 1'b1;
            win_out   <= win_nxt;
            win_first <= (cur_ox == '0) && (cur_oy == '0);
            win_last  <= (cur_ox == OX_LAST) && (cur_oy == OY_LAST);
            out_x     <= cur_ox;
            out_y     <= cur_oy;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: random-stimulus bench with a raster-image model.
// Three instances cover default, stride-2 and 3-channel K=3 builds.
module tb_conv_window_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [23:0] in_data;
    logic        out_ready = 1'b1;
    int          sel;

    logic        a_iv, a_ir, a_sof, a_or, a_ov, a_f, a_l;
    logic [199:0] a_win;
    logic [4:0]  a_ox, a_oy;
    logic        b_iv, b_ir, b_sof, b_or, b_ov, b_f, b_l;
    logic [199:0] b_win;
    logic [4:0]  b_ox, b_oy;
    logic        c_iv, c_ir, c_sof, c_or, c_ov, c_f, c_l;
    logic [215:0] c_win;
    logic [2:0]  c_ox, c_oy;

    assign a_iv  = in_valid && (sel == 0);
    assign a_sof = in_sof && (sel == 0);
    assign a_or  = (sel == 0) ? out_ready : 1'b1;
    assign b_iv  = in_valid && (sel == 1);
    assign b_sof = in_sof && (sel == 1);
    assign b_or  = (sel == 1) ? out_ready : 1'b1;
    assign c_iv  = in_valid && (sel == 2);
    assign c_sof = in_sof && (sel == 2);
    assign c_or  = (sel == 2) ? out_ready : 1'b1;

    conv_window_gen u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir),
        .in_data(in_data[7:0]), .in_sof(a_sof),
        .out_valid(a_ov), .out_ready(a_or),
        .win_out(a_win), .win_first(a_f), .win_last(a_l),
        .out_x(a_ox), .out_y(a_oy)
    );

    conv_window_gen #(.STRIDE(2)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir),
        .in_data(in_data[7:0]), .in_sof(b_sof),
        .out_valid(b_ov), .out_ready(b_or),
        .win_out(b_win), .win_first(b_f), .win_last(b_l),
        .out_x(b_ox), .out_y(b_oy)
    );

    conv_window_gen #(
        .CHANNELS(3), .KERNEL(3),
        .IMG_WIDTH(8), .IMG_HEIGHT(6)
    ) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_iv), .in_ready(c_ir),
        .in_data(in_data), .in_sof(c_sof),
        .out_valid(c_ov), .out_ready(c_or),
        .win_out(c_win), .win_first(c_f), .win_last(c_l),
        .out_x(c_ox), .out_y(c_oy)
    );

    logic         m_ir, m_ov, m_f, m_l;
    logic [255:0] m_win;
    int           m_ox, m_oy;

    always_comb begin
        m_ir  = c_ir;
        m_ov  = c_ov;
        m_f   = c_f;
        m_l   = c_l;
        m_win = {40'b0, c_win};
        m_ox  = int'(c_ox);
        m_oy  = int'(c_oy);
        if (sel == 0) begin
            m_ir  = a_ir;
            m_ov  = a_ov;
            m_f   = a_f;
            m_l   = a_l;
            m_win = {56'b0, a_win};
            m_ox  = int'(a_ox);
            m_oy  = int'(a_oy);
        end else if (sel == 1) begin
            m_ir  = b_ir;
            m_ov  = b_ov;
            m_f   = b_f;
            m_l   = b_l;
            m_win = {56'b0, b_win};
            m_ox  = int'(b_ox);
            m_oy  = int'(b_oy);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // geometry of the selected instance
    int ck = 5, cs = 1, cw = 28, chh = 28, cch = 1;

    typedef struct {
        logic [255:0] w;
        int           ox;
        int           oy;
        bit           first;
        bit           last;
    } exp_t;

    exp_t        q[$];
    logic [23:0] img [28][28];
    bit          started = 0;
    int          cx = 0, cy = 0;
    int          nwin = 0;
    int          test_id = 0;
    int          orm = 0;
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          gaps = 0;

    bit           exp_next = 0;
    bit           hold_pend = 0;
    logic [255:0] hold_win;
    int           hold_ox, hold_oy;
    bit           hold_f, hold_l;

    function automatic logic [23:0] elem(input logic [255:0] w,
                                         input int idx, input int pw);
        logic [255:0] s;
        logic [23:0]  m;
        s = w >> (idx * pw);
        m = (pw == 24) ? 24'hFFFFFF : 24'h0000FF;
        return s[23:0] & m;
    endfunction

    function automatic logic [23:0] pix_val(input int x, input int y,
                                            input int off);
        logic [23:0] v;
        v = '0;
        if (cch == 3) begin
            for (int c = 0; c < 3; c++) begin
                v[c*8 +: 8] = 8'(((y*cw + x)*3 + c + 1 + off) & 255);
            end
        end else begin
            v[7:0] = 8'((y*cw + x + off) & 255);
        end
        return v;
    endfunction

    // out_ready pattern: always, random, or a 10-cycle stall
    always @(posedge clk) begin
        #1;
        if (orm == 0) begin
            out_ready = 1'b1;
        end else if (orm == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else if (m_ov && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    end

    // model + compare, evaluated mid-cycle for the coming edge
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            started   = 0;
            cx        = 0;
            cy        = 0;
            exp_next  = 0;
            hold_pend = 0;
            chk("rst_out_valid", m_ov, 0);
            chk("rst_in_ready", m_ir, 0);
            chk("rst_win", m_win, 0);
            chk("rst_xy", {m_f, m_l, 8'(m_ox), 8'(m_oy)}, 0);
        end else begin
            if (exp_next) chk("latency", m_ov, 1);
            exp_next = 0;
            if (hold_pend) begin
                chk("hold_valid", m_ov, 1);
                chk("hold_win", m_win, hold_win);
                chk("hold_xy", {m_f, m_l, 8'(m_ox), 8'(m_oy)},
                    {hold_f, hold_l, 8'(hold_ox), 8'(hold_oy)});
            end
            hold_pend = 0;
            if (m_ov && !out_ready) begin
                chk("stall_in_ready", m_ir, 0);
                stall_seen++;
                hold_pend = 1;
                hold_win  = m_win;
                hold_ox   = m_ox;
                hold_oy   = m_oy;
                hold_f    = m_f;
                hold_l    = m_l;
            end
            if (m_ov && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_window", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    nwin++;
                    chk("win", m_win, e.w);
                    chk("out_x", m_ox, e.ox);
                    chk("out_y", m_oy, e.oy);
                    chk("first", m_f, e.first);
                    chk("last", m_l, e.last);
                    if (test_id == 1 && nwin == 1) begin
                        chk("t1_w00", elem(m_win, 0, 8), 0);
                        chk("t1_w44", elem(m_win, 24, 8), 116);
                        chk("t1_first", m_f, 1);
                    end
                    if (test_id == 1 && nwin == 576) begin
                        chk("t1_last", m_l, 1);
                        chk("t1_last_w44", elem(m_win, 24, 8), 15);
                        chk("t1_last_xy", {8'(m_ox), 8'(m_oy)},
                            {8'd23, 8'd23});
                    end
                    if (test_id == 3 && nwin == 577) begin
                        chk("t3_f2_w00", elem(m_win, 0, 8), 100);
                        chk("t3_f2_first", m_f, 1);
                    end
                    if (test_id == 6 && nwin == 2)
                        chk("t6_w00_2nd", elem(m_win, 0, 8), 2);
                    if (test_id == 6 && nwin == 12)
                        chk("t6_ox_max", m_ox, 11);
                    if (test_id == 6 && nwin == 13)
                        chk("t6_row1_w00", elem(m_win, 0, 8), 56);
                    if (test_id == 7 && nwin == 1) begin
                        chk("t7_w00", elem(m_win, 0, 24), 24'h030201);
                        chk("t7_w22", elem(m_win, 8, 24), 24'h393837);
                    end
                end
            end else if (m_ov && q.size() == 0) begin
                chk("spurious_window", 1, 0);
            end
            if (in_valid && m_ir) begin
                int px, py, pw;
                logic [23:0] pm;
                pw = 8 * cch;
                pm = (cch == 3) ? 24'hFFFFFF : 24'h0000FF;
                if (!started || in_sof) begin
                    px = 0;
                    py = 0;
                end else begin
                    px = cx;
                    py = cy;
                end
                started = 1;
                img[py][px] = in_data & pm;
                cx = px + 1;
                cy = py;
                if (cx == cw) begin
                    cx = 0;
                    cy = (py + 1 == chh) ? 0 : py + 1;
                end
                if (px >= ck-1 && py >= ck-1 &&
                    (px-ck+1) % cs == 0 && (py-ck+1) % cs == 0) begin
                    exp_t e;
                    int ow, oh;
                    ow = (cw - ck) / cs + 1;
                    oh = (chh - ck) / cs + 1;
                    e.w = '0;
                    for (int r = 0; r < ck; r++) begin
                        for (int c = 0; c < ck; c++) begin
                            e.w |= 256'(img[py-ck+1+r][px-ck+1+c])
                                   << ((r*ck + c) * pw);
                        end
                    end
                    e.ox    = (px - ck + 1) / cs;
                    e.oy    = (py - ck + 1) / cs;
                    e.first = (e.ox == 0 && e.oy == 0);
                    e.last  = (e.ox == ow-1 && e.oy == oh-1);
                    q.push_back(e);
                    exp_next = 1;
                end
            end
        end
    end

    task automatic send_pix(input logic [23:0] d, input bit sof);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        t = 0;
        forever begin
            @(negedge clk);
            if (m_ir) break;
            t++;
            if (t > 1000) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int off, input int sof_idx,
                              input int n);
        for (int i = 0; i < n; i++) begin
            send_pix(pix_val(i % cw, (i / cw) % chh, off), i == sof_idx);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || m_ov) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", (q.size() == 0) && !m_ov, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input int s);
        sel = s;
        started = 0;
        cx = 0;
        cy = 0;
        if (s == 0) begin
            ck = 5; cs = 1; cw = 28; chh = 28; cch = 1;
        end else if (s == 1) begin
            ck = 5; cs = 2; cw = 28; chh = 28; cch = 1;
        end else begin
            ck = 3; cs = 1; cw = 8; chh = 6; cch = 3;
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        set_sel(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", m_ir, 1);

        test_id = 1; nwin = 0; orm = 0; gaps = 0;
        send_frame(0, -1, 784);
        drain();
        chk("t1_count", nwin, 576);

        test_id = 2; nwin = 0; stall_seen = 0;
        stall_left = 10; orm = 2;
        send_frame(0, -1, 784);
        drain();
        chk("t2_count", nwin, 576);
        chk("t2_stall_cycles", stall_seen, 10);

        test_id = 3; nwin = 0; orm = 1; gaps = 1;
        send_frame(0, -1, 784);
        send_frame(100, -1, 784);
        drain();
        chk("t3_count", nwin, 1152);

        test_id = 4; nwin = 0;
        send_frame(0, -1, 100);
        send_frame(37, 0, 784);
        drain();
        chk("t4_count", nwin, 576);

        test_id = 5;
        send_frame(0, -1, 300);
        in_valid = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        nwin = 0;
        send_frame(5, -1, 784);
        drain();
        chk("t5_count", nwin, 576);

        set_sel(1);
        test_id = 6; nwin = 0; orm = 0; gaps = 0;
        send_frame(0, -1, 784);
        drain();
        chk("t6_count", nwin, 144);

        set_sel(2);
        test_id = 7; nwin = 0; orm = 1; gaps = 1;
        send_frame(0, -1, 48);
        drain();
        chk("t7_count", nwin, 24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
